// File: rtl/posedge_counter_pkg.sv
//------------------------------------------------------------------------------
// Module   : posedge_counter_pkg
// Brief    : Shared types and defaults for the posedge counter window sequencer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package posedge_counter_pkg;

    localparam int c_DEF_NUM_CH = 8;
    localparam int c_DEF_CNT_W  = 32;
    localparam int c_IDX_W      = 16;
    localparam int c_TMR_W      = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_COUNT  = 3'd2,
        ST_SETTLE = 3'd3,
        ST_LATCH  = 3'd4,
        ST_GAP    = 3'd5,
        ST_DONE   = 3'd6
    } state_t;

endpackage

`default_nettype wire

// File: rtl/posedge_counter_interval_timer.sv
//------------------------------------------------------------------------------
// Module   : posedge_counter_interval_timer
// Brief    : Loadable down-counter with zero flag; holds at zero until reloaded.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module posedge_counter_interval_timer #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (count_q != '0) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    assign zero_o = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/posedge_counter_window_ctrl.sv
//------------------------------------------------------------------------------
// Module   : posedge_counter_window_ctrl
// Brief    : Sequences clear/count/settle/snapshot windows for the counter bank.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module posedge_counter_window_ctrl
    import posedge_counter_pkg::*;
#(
    parameter int NUM_CH        = c_DEF_NUM_CH,
    parameter int CNT_W         = c_DEF_CNT_W,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                    S_AXI_ACLK,
    input  logic                    axi_reset,
    input  logic                    start,
    input  logic                    abort,
    input  logic [31:0]             cfg_window_len,
    input  logic [15:0]             cfg_gap_len,
    input  logic [15:0]             cfg_num_windows,
    output logic                    cnt_clear,
    output logic                    cnt_enable,
    input  logic [NUM_CH*CNT_W-1:0] cnt_values,
    output logic [NUM_CH*CNT_W-1:0] snap_data,
    output logic [c_IDX_W-1:0]      snap_index,
    output logic                    snap_valid,
    input  logic                    snap_ready,
    output logic                    busy,
    output logic                    done,
    output logic                    overrun
);

    localparam logic [c_TMR_W-1:0] c_SETTLE_LOAD = c_TMR_W'(SETTLE_CYCLES - 1);

    state_t                    state_q, state_d;
    logic [31:0]               cfg_win_q;
    logic [15:0]               cfg_gap_q;
    logic [15:0]               cfg_num_q;
    logic [c_IDX_W-1:0]        win_cnt_q;
    logic [NUM_CH*CNT_W-1:0]   snap_data_q;
    logic [c_IDX_W-1:0]        snap_index_q;
    logic                      snap_valid_q;
    logic                      overrun_q;

    logic                      w_tmr_load;
    logic [c_TMR_W-1:0]        w_tmr_val;
    logic                      w_tmr_zero;
    logic                      w_start_ok;
    logic                      w_latch;
    logic [c_IDX_W-1:0]        w_win_next;
    logic                      w_last;

    assign w_start_ok = (state_q == ST_IDLE) && start && !abort;
    assign w_latch    = (state_q == ST_LATCH) && !abort;
    assign w_win_next = win_cnt_q + c_IDX_W'(1);
    assign w_last     = (cfg_num_q != '0) && (w_win_next == cfg_num_q);

    posedge_counter_interval_timer #(
        .WIDTH (c_TMR_W)
    ) u_timer (
        .clk_i      (S_AXI_ACLK),
        .rst_i      (axi_reset),
        .load_i     (w_tmr_load),
        .load_val_i (w_tmr_val),
        .zero_o     (w_tmr_zero)
    );

    always_ff @(posedge S_AXI_ACLK or posedge axi_reset) begin
        if (axi_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Each timed state preloads the timer with (length-1) on its entry edge.
    always_comb begin
        state_d    = state_q;
        w_tmr_load = 1'b0;
        w_tmr_val  = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (w_start_ok) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                w_tmr_load = 1'b1;
                w_tmr_val  = (cfg_win_q == '0) ? '0 : cfg_win_q - 32'd1;
                state_d    = ST_COUNT;
            end
            ST_COUNT: begin
                if (w_tmr_zero) begin
                    w_tmr_load = 1'b1;
                    w_tmr_val  = c_SETTLE_LOAD;
                    state_d    = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (w_tmr_zero) state_d = ST_LATCH;
            end
            ST_LATCH: begin
                if (w_last) begin
                    state_d = ST_DONE;
                end else if (cfg_gap_q != '0) begin
                    w_tmr_load = 1'b1;
                    w_tmr_val  = {16'd0, cfg_gap_q - 16'd1};
                    state_d    = ST_GAP;
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            ST_GAP: begin
                if (w_tmr_zero) state_d = ST_CLEAR;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (abort && (state_q != ST_IDLE)) state_d = ST_IDLE;
    end

    always_ff @(posedge S_AXI_ACLK or posedge axi_reset) begin
        if (axi_reset) begin
            cfg_win_q <= '0;
            cfg_gap_q <= '0;
            cfg_num_q <= '0;
            win_cnt_q <= '0;
        end else if (w_start_ok) begin
            cfg_win_q <= cfg_window_len;
            cfg_gap_q <= cfg_gap_len;
            cfg_num_q <= cfg_num_windows;
            win_cnt_q <= '0;
        end else if (w_latch) begin
            win_cnt_q <= w_win_next;
        end
    end

    // A snapshot landing on an accepting cycle simply replaces the old one.
    always_ff @(posedge S_AXI_ACLK or posedge axi_reset) begin
        if (axi_reset) begin
            snap_data_q  <= '0;
            snap_index_q <= '0;
            snap_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            if (w_start_ok) overrun_q <= 1'b0;
            if (w_latch) begin
                snap_data_q  <= cnt_values;
                snap_index_q <= win_cnt_q;
                snap_valid_q <= 1'b1;
                if (snap_valid_q && !snap_ready) overrun_q <= 1'b1;
            end else if (snap_valid_q && snap_ready) begin
                snap_valid_q <= 1'b0;
            end
        end
    end

    assign cnt_clear  = (state_q == ST_CLEAR);
    assign cnt_enable = (state_q == ST_COUNT);
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign snap_data  = snap_data_q;
    assign snap_index = snap_index_q;
    assign snap_valid = snap_valid_q;
    assign overrun    = overrun_q;

endmodule

`default_nettype wire

// File: doc/posedge_counter_window_ctrl.md
Name: posedge_counter_window_ctrl

Overview:
Window sequencer for the 8-channel posedge counter datapath. Runs a programmed number of fixed-length counting windows: clear counters, enable for N clocks, let the pipeline settle, then snapshot all channel counts. Snapshots go to a downstream register/FIFO consumer over a valid/ready handshake. Sits between the AXI register interface (config/start/abort) and the counter bank.

Parameters:
NUM_CH, 8, number of counter channels
CNT_W, 32, width of each channel count
SETTLE_CYCLES, 2, enable-low cycles between window end and snapshot (covers counter sync/output latency), must be >=1

Ports:
S_AXI_ACLK  in  1  single clock for the whole block
axi_reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle run request; latches cfg_*
abort  in  1  one-cycle stop request
cfg_window_len  in  32  clocks per counting window; 0 treated as 1
cfg_gap_len  in  16  idle clocks between windows
cfg_num_windows  in  16  windows per run; 0 = continuous until abort
cnt_clear  out  1  synchronous clear to counter bank
cnt_enable  out  1  count enable to counter bank
cnt_values  in  NUM_CH*CNT_W  flattened live counts, ch0 in LSBs
snap_data  out  NUM_CH*CNT_W  captured counts
snap_index  out  16  window number of snap_data, from 0
snap_valid  out  1  snapshot available
snap_ready  in  1  consumer accepts snapshot
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse at normal run completion
overrun  out  1  sticky: snapshot overwritten before accepted

Behaviour:
- Reset (async, immediate): state IDLE; all outputs 0; snap_data 0; internal window counter 0.
- All outputs registered or decoded from the state register; no combinational input-to-output paths.
- IDLE: start=1 -> CLEAR; cfg_* latched; overrun cleared; window counter = 0. start while busy ignored.
- CLEAR (1 cycle): cnt_clear=1 -> COUNT; timer loaded with max(cfg_window_len,1)-1.
- COUNT: cnt_enable=1 for exactly max(W,1) cycles -> SETTLE.
- SETTLE: SETTLE_CYCLES cycles, enable low -> LATCH.
- LATCH (1 cycle): snap_data <= cnt_values; snap_index <= window counter; snap_valid <= 1; window counter +1 (16-bit, wraps). If snap_valid already 1 and no handshake this cycle, overrun <= 1 and data is overwritten. If handshake and LATCH coincide, valid stays 1 with new data, no overrun. Next: DONE if N!=0 and incremented count==N; else GAP if G>0; else CLEAR.
- GAP: G cycles, all outputs idle -> CLEAR.
- DONE (1 cycle): done=1 -> IDLE.
- Handshake: snap_valid holds, with stable data, until snap_valid&snap_ready; then it clears next cycle (unless reloaded by LATCH).
- abort: from any non-IDLE state -> IDLE next cycle. No snapshot, no done pulse; a pending snap_valid/data is kept. abort and start in the same cycle in IDLE: abort wins, stay IDLE.
- Timing with start high in cycle 0: cnt_clear in cycle 1; cnt_enable in cycles 2..W+1; LATCH in cycle W+2+S; snap_valid from cycle W+3+S. Window period = 1+W+S+1+G.

Decomposition:
- Package posedge_counter_pkg: state enum (IDLE, CLEAR, COUNT, SETTLE, LATCH, GAP, DONE), default NUM_CH/CNT_W, index width.
- One sub-module: posedge_counter_interval_timer. It is a loadable down-counter with a zero flag, shared by COUNT, SETTLE and GAP.

Test Plan:
- W=10,S=2,G=0,N=1, ready=1, start@0 -> clear@1; enable@2..11; snap_valid@15 with index 0 and data = cnt_values@14; done@15; busy low @16.
- N=3,G=5, ready=1 -> three snapshots, indices 0,1,2, 19 cycles apart; single done pulse; overrun=0.
- N=2,G=0, ready=0 -> second LATCH sets overrun=1; snap_data = window-1 counts, index 1; valid held. Raising ready clears valid next cycle; overrun stays 1 until next start.
- abort during COUNT cycle 6 -> cnt_enable low from cycle 7; busy low cycle 7; no snap_valid; no done. start+abort together in IDLE -> stays IDLE.
- W=0,N=0,G=0 -> 1-cycle enable windows run continuously; snapshots every 5 cycles (S=2); index increments; runs until abort.
- axi_reset asserted mid-COUNT, off clock edge -> all outputs 0 immediately. After release, run restarts cleanly on the next start.
